// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor table write-port controller:
// table geometry defaults, the invalid tag, the counter reset value, the
// controller state encoding and the buffered update record.
package bp_pkg;

   localparam int DEF_ENTRY_NUM = 256;
   localparam int DEF_IDX_WIDTH = $clog2(DEF_ENTRY_NUM);
   localparam int DEF_UPD_DEPTH = 4;

   // Odd value: fetch pcs are word aligned, so this tag can never hit.
   localparam logic [31:0] INVALID_TAG = 32'h0000_0001;

   // Value the counter array takes on an invalidate write (weakly not taken).
   localparam logic [1:0] CNT_RESET = 2'b01;

   typedef enum logic {
      SWEEP = 1'b0,
      IDLE  = 1'b1
   } bp_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
   } upd_rec_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding resolved branch updates until the table
// write port is free. A push into a full FIFO is accepted when a pop happens
// in the same cycle. Clear empties the FIFO and wins over push and pop.
module bp_upd_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = DEF_UPD_DEPTH
) (
   input  logic     cpu_clk,
   input  logic     cpu_rst,
   input  logic     push,
   input  logic     pop,
   input  logic     clear,
   input  upd_rec_t din,
   output upd_rec_t dout,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   upd_rec_t      mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_pop;
   logic          do_push;

   // The extra pointer bit separates the full and empty cases.
   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      dout    = mem[rd_ptr[AW-1:0]];
   end

   // Pointer bookkeeping; clear drops every queued record at once.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge cpu_clk) begin
      if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/bp_table_ctrl.sv
// Write-port controller for the BHT tag table, BTT target table and 2-bit
// counter array. After reset or a flush request it sweeps every entry with
// an invalidate write; otherwise it drains buffered execute-stage updates
// onto the single write port, one per cycle, in arrival order.
// Optional build macro BP_PERF_CNT_EN adds 32-bit performance counters.
module bp_table_ctrl
   import bp_pkg::*;
#(
   parameter int ENTRY_NUM = DEF_ENTRY_NUM,
   parameter int IDX_WIDTH = $clog2(ENTRY_NUM),
   parameter int UPD_DEPTH = DEF_UPD_DEPTH
) (
   input  logic                 cpu_clk,
   input  logic                 cpu_rst,
   input  logic                 flush_req,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic [31:0]          upd_target,
   input  logic                 upd_taken,
   output logic                 tbl_wen,
   output logic [IDX_WIDTH-1:0] tbl_waddr,
   output logic [31:0]          tbl_wtag,
   output logic [31:0]          tbl_wtarget,
   output logic                 tbl_wtaken,
   output logic                 tbl_wclr,
   output logic                 predict_en,
   output logic                 flush_busy,
   output logic                 upd_drop
`ifdef BP_PERF_CNT_EN
   ,
   output logic [31:0]          perf_upd_cnt,
   output logic [31:0]          perf_taken_cnt,
   output logic [31:0]          perf_drop_cnt,
   output logic [31:0]          perf_flush_cnt
`endif
);

   localparam logic [IDX_WIDTH:0] LAST_IDX = (IDX_WIDTH+1)'(ENTRY_NUM - 1);

   bp_state_t          state;
   logic [IDX_WIDTH:0] idx;

   upd_rec_t           fifo_din;
   upd_rec_t           fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic               drop_next;

   // An update arriving with a flush belongs to the old context and is
   // discarded; pops only happen in IDLE and never alongside a flush.
   always_comb begin
      fifo_din  = '{pc: upd_pc, target: upd_target, taken: upd_taken};
      fifo_push = upd_valid && !flush_req;
      fifo_pop  = (state == IDLE) && !fifo_empty && !flush_req;
      drop_next = fifo_push && fifo_full && !fifo_pop;
   end

   bp_upd_fifo #(
      .DEPTH (UPD_DEPTH)
   ) u_upd_fifo (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .clear   (flush_req),
      .din     (fifo_din),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Controller FSM: sweep writes take the port in SWEEP, queued updates in IDLE.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state       <= SWEEP;
         idx         <= '0;
         tbl_wen     <= 1'b0;
         tbl_waddr   <= '0;
         tbl_wtag    <= '0;
         tbl_wtarget <= '0;
         tbl_wtaken  <= 1'b0;
         tbl_wclr    <= 1'b0;
         predict_en  <= 1'b0;
         flush_busy  <= 1'b1;
         upd_drop    <= 1'b0;
      end else begin
         upd_drop <= drop_next;
         tbl_wen  <= 1'b0;
         tbl_wclr <= 1'b0;
         if (flush_req) begin
            state      <= SWEEP;
            idx        <= '0;
            predict_en <= 1'b0;
            flush_busy <= 1'b1;
         end else begin
            case (state)
               SWEEP: begin
                  tbl_wen     <= 1'b1;
                  tbl_wclr    <= 1'b1;
                  tbl_waddr   <= idx[IDX_WIDTH-1:0];
                  tbl_wtag    <= INVALID_TAG;
                  tbl_wtarget <= '0;
                  tbl_wtaken  <= 1'b0;
                  predict_en  <= 1'b0;
                  flush_busy  <= 1'b1;
                  idx         <= idx + 1'b1;
                  if (idx == LAST_IDX) state <= IDLE;
               end
               IDLE: begin
                  predict_en <= 1'b1;
                  flush_busy <= 1'b0;
                  if (fifo_pop) begin
                     tbl_wen     <= 1'b1;
                     tbl_waddr   <= fifo_dout.pc[IDX_WIDTH+1:2];
                     tbl_wtag    <= fifo_dout.pc;
                     tbl_wtarget <= fifo_dout.target;
                     tbl_wtaken  <= fifo_dout.taken;
                  end
               end
               default: begin
                  state <= SWEEP;
                  idx   <= '0;
               end
            endcase
         end
      end
   end

`ifdef BP_PERF_CNT_EN
   // Event counters survive flushes; only cpu_rst clears them.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         perf_upd_cnt   <= '0;
         perf_taken_cnt <= '0;
         perf_drop_cnt  <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (fifo_pop)                   perf_upd_cnt   <= perf_upd_cnt + 1'b1;
         if (fifo_pop && fifo_dout.taken) perf_taken_cnt <= perf_taken_cnt + 1'b1;
         if (drop_next)                  perf_drop_cnt  <= perf_drop_cnt + 1'b1;
         if (flush_req)                  perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl. Expected table writes come from a
// queue model of the update buffer and from the sweep rules (every index in
// order, invalid tag, zero target).
module tb_bp_table_ctrl;
   import bp_pkg::*;

   localparam int N  = DEF_ENTRY_NUM;
   localparam int IW = DEF_IDX_WIDTH;
   localparam int D  = DEF_UPD_DEPTH;

   logic          cpu_clk = 1'b0;
   logic          cpu_rst;
   logic          flush_req;
   logic          upd_valid;
   logic [31:0]   upd_pc;
   logic [31:0]   upd_target;
   logic          upd_taken;
   logic          tbl_wen;
   logic [IW-1:0] tbl_waddr;
   logic [31:0]   tbl_wtag;
   logic [31:0]   tbl_wtarget;
   logic          tbl_wtaken;
   logic          tbl_wclr;
   logic          predict_en;
   logic          flush_busy;
   logic          upd_drop;
`ifdef BP_PERF_CNT_EN
   logic [31:0]   perf_upd_cnt;
   logic [31:0]   perf_taken_cnt;
   logic [31:0]   perf_drop_cnt;
   logic [31:0]   perf_flush_cnt;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   logic [IW+67:0] sweep_obs;
   logic [IW+66:0] upd_obs;
   assign sweep_obs = {tbl_wen, tbl_wclr, tbl_waddr, tbl_wtag, tbl_wtarget, predict_en, flush_busy};
   assign upd_obs   = {tbl_wen, tbl_wclr, tbl_waddr, tbl_wtag, tbl_wtarget, tbl_wtaken};

   bp_table_ctrl dut (
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .flush_req   (flush_req),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .upd_taken   (upd_taken),
      .tbl_wen     (tbl_wen),
      .tbl_waddr   (tbl_waddr),
      .tbl_wtag    (tbl_wtag),
      .tbl_wtarget (tbl_wtarget),
      .tbl_wtaken  (tbl_wtaken),
      .tbl_wclr    (tbl_wclr),
      .predict_en  (predict_en),
      .flush_busy  (flush_busy),
      .upd_drop    (upd_drop)
`ifdef BP_PERF_CNT_EN
      ,
      .perf_upd_cnt   (perf_upd_cnt),
      .perf_taken_cnt (perf_taken_cnt),
      .perf_drop_cnt  (perf_drop_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   // Free-running 100 MHz core clock.
   always #5 cpu_clk = ~cpu_clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic drive_quiet();
      flush_req  = 1'b0;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_target = '0;
      upd_taken  = 1'b0;
   endtask

   task automatic drive_update(input upd_rec_t r);
      upd_valid  = 1'b1;
      upd_pc     = r.pc;
      upd_target = r.target;
      upd_taken  = r.taken;
   endtask

   function automatic upd_rec_t rand_rec();
      upd_rec_t r;
      r.pc     = $urandom & 32'hFFFF_FFFC;
      r.target = $urandom;
      r.taken  = 1'($urandom_range(0, 1));
      return r;
   endfunction

   // Table write the spec demands for a buffered update record.
   function automatic logic [IW+66:0] exp_write(input upd_rec_t r);
      logic [IW-1:0] a;
      a = IW'((r.pc >> 2) % N);
      return {1'b1, 1'b0, a, r.pc, r.target, r.taken};
   endfunction

   function automatic logic [IW+67:0] exp_sweep(input int i);
      return {1'b1, 1'b1, IW'(i), INVALID_TAG, 32'h0, 1'b0, 1'b1};
   endfunction

   task automatic test_reset();
      drive_quiet();
      cpu_rst = 1'b1;
      #3;
      tests_run++;
      if ({tbl_wen, tbl_wclr, predict_en, flush_busy, upd_drop} !== 5'b00010) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got %b want 00010",
                  {tbl_wen, tbl_wclr, predict_en, flush_busy, upd_drop});
      end
      tick();
      tick();
      cpu_rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         tick();
         tests_run++;
         if (sweep_obs !== exp_sweep(i)) begin
            tests_failed++;
            $display("[TB] FAIL reset_sweep[%0d]: got %h want %h", i, sweep_obs, exp_sweep(i));
         end
      end
      tick();
      tests_run++;
      if ({tbl_wen, predict_en, flush_busy} !== 3'b010) begin
         tests_failed++;
         $display("[TB] FAIL reset_sweep_end: got %b want 010", {tbl_wen, predict_en, flush_busy});
      end
   endtask

   task automatic test_single_update();
      upd_rec_t r;
      r = '{pc: 32'h0000_0104, target: 32'h0000_0200, taken: 1'b1};
      drive_update(r);
      tick();
      drive_quiet();
      tests_run++;
      if (tbl_wen !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL single_early: wen got %b want 0", tbl_wen);
      end
      tick();
      tests_run++;
      if (upd_obs !== {1'b1, 1'b0, IW'(8'h41), 32'h104, 32'h200, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL single_write: got %h want %h", upd_obs,
                  {1'b1, 1'b0, IW'(8'h41), 32'h104, 32'h200, 1'b1});
      end
      tick();
      tests_run++;
      if (tbl_wen !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL single_after: wen got %b want 0", tbl_wen);
      end
   endtask

   task automatic test_random_updates();
      upd_rec_t q[$];
      upd_rec_t r;
      bit       will_pop;
      for (int c = 0; c < 300; c++) begin
         will_pop = (q.size() != 0);
         if ($urandom_range(0, 99) < 55) begin
            r = rand_rec();
            drive_update(r);
            q.push_back(r);
         end else begin
            drive_quiet();
         end
         tick();
         tests_run++;
         if (will_pop) begin
            if (upd_obs !== exp_write(q[0]) || upd_drop !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL random_write[%0d]: got %h drop %b want %h drop 0",
                        c, upd_obs, upd_drop, exp_write(q[0]));
            end
            void'(q.pop_front());
         end else if (tbl_wen !== 1'b0 || upd_drop !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL random_idle[%0d]: wen %b drop %b want 0 0", c, tbl_wen, upd_drop);
         end
      end
      drive_quiet();
      for (int c = 0; c < 3; c++) begin
         will_pop = (q.size() != 0);
         tick();
         tests_run++;
         if (will_pop) begin
            if (upd_obs !== exp_write(q[0])) begin
               tests_failed++;
               $display("[TB] FAIL random_tail[%0d]: got %h want %h", c, upd_obs, exp_write(q[0]));
            end
            void'(q.pop_front());
         end else if (tbl_wen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL random_tail_idle[%0d]: wen %b want 0", c, tbl_wen);
         end
      end
   endtask

   task automatic test_sweep_overflow();
      upd_rec_t q[$];
      upd_rec_t r;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tests_run++;
      if ({tbl_wen, predict_en, flush_busy} !== 3'b001) begin
         tests_failed++;
         $display("[TB] FAIL ovf_flush: got %b want 001", {tbl_wen, predict_en, flush_busy});
      end
      for (int i = 0; i < N; i++) begin
         if (i < 6) begin
            r = rand_rec();
            drive_update(r);
            if (i < D) q.push_back(r);
         end else begin
            drive_quiet();
         end
         tick();
         tests_run++;
         if (sweep_obs !== exp_sweep(i) || upd_drop !== (i >= D && i < 6)) begin
            tests_failed++;
            $display("[TB] FAIL ovf_sweep[%0d]: got %h drop %b want %h drop %b",
                     i, sweep_obs, upd_drop, exp_sweep(i), (i >= D && i < 6));
         end
      end
      for (int k = 0; k < D; k++) begin
         tick();
         tests_run++;
         if (upd_obs !== exp_write(q[k]) || predict_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovf_drain[%0d]: got %h pen %b want %h pen 1",
                     k, upd_obs, predict_en, exp_write(q[k]));
         end
      end
      tick();
      tests_run++;
      if (tbl_wen !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ovf_drain_end: wen got %b want 0", tbl_wen);
      end
   endtask

   task automatic test_flush_idle();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i < 3) drive_update(rand_rec());
         else       drive_quiet();
         tick();
      end
      tests_run++;
      if ({tbl_waddr, tbl_wclr} !== {IW'(N - 1), 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL fidle_last_sweep: addr %0d clr %b want %0d 1", tbl_waddr, tbl_wclr, N - 1);
      end
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tests_run++;
      if ({tbl_wen, predict_en, flush_busy} !== 3'b001) begin
         tests_failed++;
         $display("[TB] FAIL fidle_flush: got %b want 001", {tbl_wen, predict_en, flush_busy});
      end
      for (int i = 0; i < N; i++) begin
         tick();
         tests_run++;
         if (sweep_obs !== exp_sweep(i)) begin
            tests_failed++;
            $display("[TB] FAIL fidle_sweep[%0d]: got %h want %h", i, sweep_obs, exp_sweep(i));
         end
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         tests_run++;
         if ({tbl_wen, predict_en} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL fidle_no_stale[%0d]: wen/pen got %b want 01", k, {tbl_wen, predict_en});
         end
      end
   endtask

   task automatic test_flush_mid_sweep();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i <= 100; i++) begin
         tick();
         tests_run++;
         if (sweep_obs !== exp_sweep(i)) begin
            tests_failed++;
            $display("[TB] FAIL fmid_pre[%0d]: got %h want %h", i, sweep_obs, exp_sweep(i));
         end
      end
      flush_req = 1'b1;
      upd_valid = 1'b1;
      tick();
      drive_quiet();
      tests_run++;
      if ({tbl_wen, predict_en, flush_busy} !== 3'b001) begin
         tests_failed++;
         $display("[TB] FAIL fmid_flush: got %b want 001", {tbl_wen, predict_en, flush_busy});
      end
      for (int i = 0; i < N; i++) begin
         tick();
         tests_run++;
         if (sweep_obs !== exp_sweep(i)) begin
            tests_failed++;
            $display("[TB] FAIL fmid_sweep[%0d]: got %h want %h", i, sweep_obs, exp_sweep(i));
         end
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         tests_run++;
         if ({tbl_wen, predict_en, flush_busy} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL fmid_idle[%0d]: got %b want 010", k, {tbl_wen, predict_en, flush_busy});
         end
      end
   endtask

   task automatic test_reset_midop();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < 50; i++) tick();
      cpu_rst = 1'b1;
      #1;
      tests_run++;
      if ({tbl_wen, tbl_wclr, predict_en, flush_busy, upd_drop} !== 5'b00010) begin
         tests_failed++;
         $display("[TB] FAIL midrst_async: got %b want 00010",
                  {tbl_wen, tbl_wclr, predict_en, flush_busy, upd_drop});
      end
      tick();
      cpu_rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         tick();
         tests_run++;
         if (sweep_obs !== exp_sweep(i)) begin
            tests_failed++;
            $display("[TB] FAIL midrst_sweep[%0d]: got %h want %h", i, sweep_obs, exp_sweep(i));
         end
      end
      tick();
      tests_run++;
      if ({tbl_wen, predict_en, flush_busy} !== 3'b010) begin
         tests_failed++;
         $display("[TB] FAIL midrst_idle: got %b want 010", {tbl_wen, predict_en, flush_busy});
      end
   endtask

`ifdef BP_PERF_CNT_EN
   task automatic test_perf_counters();
      upd_rec_t r;
      int       exp_taken;
      exp_taken = 0;
      cpu_rst = 1'b1;
      tick();
      cpu_rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i < 6) begin
            r = rand_rec();
            drive_update(r);
            if (i < D && r.taken) exp_taken++;
         end else begin
            drive_quiet();
         end
         tick();
      end
      for (int k = 0; k < D + 1; k++) tick();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();
      tests_run++;
      if (perf_upd_cnt !== 32'd4 || perf_drop_cnt !== 32'd2 || perf_flush_cnt !== 32'd1 ||
          perf_taken_cnt !== 32'(exp_taken)) begin
         tests_failed++;
         $display("[TB] FAIL perf_counters: upd %0d drop %0d flush %0d taken %0d want 4 2 1 %0d",
                  perf_upd_cnt, perf_drop_cnt, perf_flush_cnt, perf_taken_cnt, exp_taken);
      end
   endtask
`endif

   // Scenario sequence; each task leaves the controller in IDLE.
   initial begin
      test_reset();
      test_single_update();
      test_random_updates();
      test_sweep_overflow();
      test_flush_idle();
      test_flush_mid_sweep();
      test_reset_midop();
`ifdef BP_PERF_CNT_EN
      test_perf_counters();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bp_table_ctrl.md
Name: bp_table_ctrl

Overview:
Write-port controller for the branch predictor tables: BHT tag table, BTT target table and the 2-bit counter array.
- Sequences an invalidate sweep of all entries after reset and on flush requests (fence.i, context switch).
- Buffers execute-stage branch updates in a small FIFO.
- Serialises sweep writes and updates onto the single table write port.
- Gates prediction while table contents are invalid.

Parameters:
ENTRY_NUM, 256, number of table entries (power of 2)
IDX_WIDTH, $clog2(ENTRY_NUM), table index width
UPD_DEPTH, 4, update FIFO depth (power of 2, >=2)
INVALID_TAG, 32'h0000_0001, tag written by the sweep; odd, so it never matches a fetch pc

Ports:
cpu_clk  in  1  core clock
cpu_rst  in  1  asynchronous active-high reset
flush_req  in  1  single-cycle request to invalidate all entries
upd_valid  in  1  execute-stage resolved branch update
upd_pc  in  32  branch pc
upd_target  in  32  resolved target pc
upd_taken  in  1  resolved direction
tbl_wen  out  1  table write enable
tbl_waddr  out  IDX_WIDTH  write index
tbl_wtag  out  32  tag data (BHT)
tbl_wtarget  out  32  target data (BTT)
tbl_wtaken  out  1  direction for counter update
tbl_wclr  out  1  1 = invalidate write; counter is forced to weakly-not-taken (2'b01)
predict_en  out  1  1 = table contents valid, prediction permitted
flush_busy  out  1  sweep in progress
upd_drop  out  1  one-cycle pulse: update lost because the FIFO was full

Behaviour:
- Reset (asynchronous): all outputs low except flush_busy=1; state=SWEEP; sweep index=0; FIFO empty. The tables themselves have no reset, so the sweep is mandatory.
- States: SWEEP and IDLE. All outputs are registered.
- SWEEP:
  - Each cycle: tbl_wen=1, tbl_wclr=1, tbl_waddr=idx, tbl_wtag=INVALID_TAG, tbl_wtarget=0; then idx++.
  - After writing idx=ENTRY_NUM-1, go to IDLE. A full sweep is exactly ENTRY_NUM write cycles.
  - predict_en=0 and flush_busy=1 throughout.
- IDLE:
  - predict_en=1 and flush_busy=0.
  - If the FIFO is non-empty, pop one entry per cycle and drive tbl_wen=1, tbl_wclr=0, tbl_waddr=upd_pc[IDX_WIDTH+1:2], tbl_wtag=upd_pc, tbl_wtarget, tbl_wtaken.
  - If the FIFO is empty, tbl_wen=0.
- Update path:
  - upd_valid pushes into the FIFO in any state.
  - Minimum latency: upd_valid in cycle N gives tbl_wen in cycle N+2 (push, then registered pop).
  - Writes leave strictly in FIFO order, including repeated updates to the same index.
- FIFO full:
  - A push is dropped and upd_drop=1 for one cycle, unless a pop happens the same cycle; a simultaneous push and pop on a full FIFO is accepted.
- flush_req in IDLE:
  - Next cycle state=SWEEP, idx=0, predict_en=0.
  - FIFO is cleared; stale-context updates are discarded. An upd_valid in the same cycle as flush_req is also discarded.
- flush_req during SWEEP: restart from idx=0 and clear the FIFO.
- Updates arriving during SWEEP (no flush pending) are kept and drained after the sweep.
- Priority on the write port: sweep > FIFO pop. No FIFO pop occurs in SWEEP.
- cpu_rst mid-operation: immediate return to the reset state; the sweep restarts from 0.
- Index wrap: idx is IDX_WIDTH+1 bits wide; terminal count is compared before the increment, so it never wraps into index 0.

Optional Feature:
BP_PERF_CNT_EN
- Defined: adds 32-bit output counters perf_upd_cnt (FIFO pops), perf_taken_cnt (pops with upd_taken=1), perf_drop_cnt (upd_drop pulses) and perf_flush_cnt (accepted flush_req).
  - Counters wrap modulo 2^32.
  - Cleared only by cpu_rst; unaffected by flush.
- Undefined: ports and logic absent; core behaviour unchanged.

Decomposition:
- Shared package bp_pkg holds:
  - ENTRY_NUM and IDX_WIDTH defaults;
  - INVALID_TAG;
  - the counter reset value 2'b01;
  - state encoding (SWEEP=1'b0, IDLE=1'b1);
  - the update-record typedef {pc[31:0], target[31:0], taken}.
- One sub-module: bp_upd_fifo.
  - Synchronous FIFO, parameterised depth.
  - Ports: push, pop, clear, full, empty, data in/out.
  - Simultaneous push and pop allowed when full.

Test Plan:
- Release cpu_rst, no stimulus -> 256 consecutive tbl_wen with tbl_wclr=1, addresses 0..255. predict_en rises the cycle after address 255; flush_busy falls in the same cycle.
- In IDLE: upd_valid with pc=0x0000_0104, target=0x0000_0200, taken=1 -> two cycles later: tbl_wen=1, waddr=0x41, wtag=0x104, wtarget=0x200, wtaken=1.
- During the sweep, push 6 updates back-to-back -> first 4 accepted, upd_drop pulses twice. After the sweep ends, the 4 kept updates are written in order on 4 consecutive cycles.
- flush_req in IDLE with 3 entries queued -> no queued writes appear; 256-cycle sweep from index 0; predict_en=0 for the whole sweep.
- flush_req at sweep index 100 -> next write is index 0, total 256 further sweep writes before IDLE.
- With BP_PERF_CNT_EN: run the 6-push scenario followed by one flush -> perf_upd_cnt=4, perf_drop_cnt=2, perf_flush_cnt=1.
